// File: rtl/mem_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mem_burst_ctrl
//   Memory-side controller sitting behind the I/D-cache arbiter. A single
//   cache-line request (read or write) is turned into one address phase
//   followed by LINE_W/BUS_W data beats on the narrow bus. Completion of the
//   line is signalled by a one-cycle mem_data_valid pulse. Only one request
//   is in flight at a time; requests arriving while busy are ignored.
//
// Optional feature: define MEM_TIMEOUT_EN to enable a per-phase watchdog.
//   When enabled, TMO_CYC cycles without bus progress in REQ_ADDR, RD_DATA
//   or WR_DATA abort the transfer with mem_error qualifying the pulse.
//   When not defined, the controller waits indefinitely and mem_error is 0.
//
// Ports
//   clk, rst          clock (posedge) and synchronous active-high reset
//   mem_req           line request, sampled only while idle
//   mem_address       line address (offset bits dropped on the bus)
//   mem_wr_en         1 = write line, 0 = read line
//   mem_wdata         write line, captured with the request
//   mem_rdata         assembled read line (registered)
//   mem_data_valid    one-cycle completion pulse
//   mem_busy          controller not idle
//   mem_error         transfer aborted by watchdog (with mem_data_valid)
//   bus_reqcyc        address / write-beat valid
//   bus_req           aligned address or write beat
//   bus_req_wr        write flag accompanying bus_reqcyc
//   bus_reqack        bus accepted the current bus_req
//   bus_respcyc       read beat valid
//   bus_resp          read beat data
//   bus_respack       read beat accepted (combinational)
// ---------------------------------------------------------------------------
module mem_burst_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int BUS_W   = 64,
    parameter int LINE_W  = 512,
    parameter int TMO_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_wr_en,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_data_valid,
    output logic              mem_busy,
    output logic              mem_error,
    output logic              bus_reqcyc,
    output logic [BUS_W-1:0]  bus_req,
    output logic              bus_req_wr,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [BUS_W-1:0]  bus_resp,
    output logic              bus_respack
);

    localparam int BEATS = LINE_W / BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_ADDR,
        S_RD_DATA,
        S_WR_DATA,
        S_DONE
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               wr_q,     wr_d;
    logic [LINE_W-1:0]  wdata_q,  wdata_d;
    logic [LINE_W-1:0]  rdata_q,  rdata_d;
    logic               valid_q,  valid_d;
    logic               error_q,  error_d;
    logic               reqcyc_q, reqcyc_d;
    logic [BUS_W-1:0]   req_q,    req_d;
    logic               req_wr_q, req_wr_d;
    logic               tmo_hit;

    assign cnt_nxt = cnt_q + 1'b1;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             in_xfer;
    logic             progress;

    assign in_xfer  = (state_q == S_REQ_ADDR) || (state_q == S_RD_DATA) ||
                      (state_q == S_WR_DATA);
    assign progress = (((state_q == S_REQ_ADDR) || (state_q == S_WR_DATA)) && bus_reqack) ||
                      ((state_q == S_RD_DATA) && bus_respcyc);

    // Held at zero while idle so it starts from zero on entering REQ_ADDR;
    // any ack or beat restarts the count. A cycle with progress never times out.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (in_xfer) begin
            tmo_d = progress ? '0 : tmo_q + 1'b1;
        end
    end

    assign tmo_hit = in_xfer && !progress && (tmo_q == TMO_W'(TMO_CYC - 1));
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TMO_CYC == 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        reqcyc_d = reqcyc_q;
        req_d    = req_q;
        req_wr_d = req_wr_q;

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    state_d  = S_REQ_ADDR;
                    cnt_d    = '0;
                    wr_d     = mem_wr_en;
                    wdata_d  = mem_wdata;
                    reqcyc_d = 1'b1;
                    req_d    = BUS_W'(mem_address & ADDR_MASK);
                    req_wr_d = mem_wr_en;
                end
            end

            S_REQ_ADDR: begin
                if (bus_reqack) begin
                    if (wr_q) begin
                        // Beat 0 goes out immediately behind the address.
                        state_d = S_WR_DATA;
                        req_d   = wdata_q[BUS_W-1:0];
                    end else begin
                        state_d  = S_RD_DATA;
                        reqcyc_d = 1'b0;
                        req_d    = '0;
                        req_wr_d = 1'b0;
                    end
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    error_d  = 1'b1;
                    reqcyc_d = 1'b0;
                    req_d    = '0;
                    req_wr_d = 1'b0;
                end
            end

            S_WR_DATA: begin
                if (bus_reqack) begin
                    cnt_d = cnt_nxt;
                    if (cnt_q == LAST_BEAT) begin
                        state_d  = S_DONE;
                        valid_d  = 1'b1;
                        reqcyc_d = 1'b0;
                        req_d    = '0;
                        req_wr_d = 1'b0;
                    end else begin
                        req_d = wdata_q[cnt_nxt*BUS_W +: BUS_W];
                    end
                end else if (tmo_hit) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    error_d  = 1'b1;
                    reqcyc_d = 1'b0;
                    req_d    = '0;
                    req_wr_d = 1'b0;
                end
            end

            S_RD_DATA: begin
                if (bus_respcyc) begin
                    rdata_d[cnt_q*BUS_W +: BUS_W] = bus_resp;
                    cnt_d = cnt_nxt;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    error_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            reqcyc_q <= 1'b0;
            req_q    <= '0;
            req_wr_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            reqcyc_q <= reqcyc_d;
            req_q    <= req_d;
            req_wr_q <= req_wr_d;
`ifdef MEM_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Captured request payload; only meaningful while a write is in flight.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
    end

    assign mem_rdata      = rdata_q;
    assign mem_data_valid = valid_q;
    assign mem_busy       = (state_q != S_IDLE);
    assign mem_error      = error_q;
    assign bus_reqcyc     = reqcyc_q;
    assign bus_req        = req_q;
    assign bus_req_wr     = req_wr_q;
    assign bus_respack    = (state_q == S_RD_DATA) && bus_respcyc;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
module tb_mem_burst_ctrl;

    localparam int ADDR_W = 64;
    localparam int BUS_W  = 64;
    localparam int LINE_W = 512;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_req = 1'b0;
    logic [ADDR_W-1:0] mem_address = '0;
    logic              mem_wr_en = 1'b0;
    logic [LINE_W-1:0] mem_wdata = '0;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_data_valid;
    logic              mem_busy;
    logic              mem_error;
    logic              bus_reqcyc;
    logic [BUS_W-1:0]  bus_req;
    logic              bus_req_wr;
    logic              bus_reqack = 1'b0;
    logic              bus_respcyc = 1'b0;
    logic [BUS_W-1:0]  bus_resp = '0;
    logic              bus_respack;

    mem_burst_ctrl #(
        .ADDR_W (ADDR_W),
        .BUS_W  (BUS_W),
        .LINE_W (LINE_W),
        .TMO_CYC(TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req       (mem_req),
        .mem_address   (mem_address),
        .mem_wr_en     (mem_wr_en),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_data_valid(mem_data_valid),
        .mem_busy      (mem_busy),
        .mem_error     (mem_error),
        .bus_reqcyc    (bus_reqcyc),
        .bus_req       (bus_req),
        .bus_req_wr    (bus_req_wr),
        .bus_reqack    (bus_reqack),
        .bus_respcyc   (bus_respcyc),
        .bus_resp      (bus_resp),
        .bus_respack   (bus_respack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Expected completion: line content, error flag, cycle count at which the
    // pulse is seen on the falling edge (-1 = not timed).
    typedef struct {
        logic [LINE_W-1:0] rdata;
        logic              err;
        int                at;
    } exp_t;

    exp_t sb[$];
    logic [LINE_W-1:0] cur_line = '0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [63:0] base, input logic [63:0] step);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + step * 64'(k);
        return l;
    endfunction

    // Monitor: every completion pulse must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (mem_data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_rdata", mem_rdata, e.rdata);
                chk("pulse_error", mem_error, e.err);
                if (e.at >= 0) chk("pulse_cycle", cyc, e.at);
            end
        end
    end

    task automatic push_exp(input logic [LINE_W-1:0] l, input logic err, input int at);
        exp_t e;
        e.rdata = l;
        e.err   = err;
        e.at    = at;
        sb.push_back(e);
    endtask

    task automatic start_req(input logic [63:0] a, input logic wr, input logic [LINE_W-1:0] wd);
        mem_req     = 1'b1;
        mem_address = a;
        mem_wr_en   = wr;
        mem_wdata   = wd;
        @(posedge clk); #1;
    endtask

    task automatic addr_phase(input logic [63:0] aligned, input logic wr);
        chk("addr_reqcyc", bus_reqcyc, 1'b1);
        chk("addr_bus_req", bus_req, aligned);
        chk("addr_req_wr", bus_req_wr, wr);
        chk("addr_respack", bus_respack, 1'b0);
        bus_reqack = 1'b1;
        @(posedge clk); #1;
        bus_reqack = 1'b0;
        if (!wr) chk("rd_reqcyc_low", bus_reqcyc, 1'b0);
    endtask

    task automatic rd_beats(input logic [LINE_W-1:0] line, input int gap, input int n);
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                bus_respcyc = 1'b0;
                #1;
                chk("respack_gap", bus_respack, 1'b0);
                @(posedge clk); #1;
            end
            bus_respcyc = 1'b1;
            bus_resp    = line[k*64 +: 64];
            #1;
            chk("respack_beat", bus_respack, 1'b1);
            @(posedge clk); #1;
        end
        bus_respcyc = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_rdata", mem_rdata, '0);
        chk("rst_valid", mem_data_valid, 1'b0);
        chk("rst_busy", mem_busy, 1'b0);
        chk("rst_error", mem_error, 1'b0);
        chk("rst_reqcyc", bus_reqcyc, 1'b0);
        chk("rst_bus_req", bus_req, '0);
        chk("rst_req_wr", bus_req_wr, 1'b0);
        chk("rst_respack", bus_respack, 1'b0);
    endtask

    initial begin
        logic [LINE_W-1:0] l1, wl, la, lb, lc, ld, le, lf;
        l1 = mk_line(64'h0, 64'h1);
        wl = mk_line(64'h0, 64'h11);
        la = mk_line(64'hA000, 64'h1);
        lb = mk_line(64'hB000, 64'h3);
        lc = mk_line(64'hC0DE_0000_0000_0000, 64'h0101_0101_0101_0101);
        ld = mk_line(64'hD000, 64'h5);
        le = mk_line(64'hE000_0000_0000_0001, 64'h2);
        lf = mk_line(64'hF00F, 64'h7);

        // Reset state, with a stray read beat present
        rst = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_stray_respack", bus_respack, 1'b0);
            chk("idle_stray_busy", mem_busy, 1'b0);
        end
        bus_respcyc = 1'b0;

        // 1: read, immediate ack, back-to-back beats 0..7
        push_exp(l1, 1'b0, cyc + 10);
        start_req(64'h1000, 1'b0, '0);
        mem_req = 1'b0;
        addr_phase(64'h1000, 1'b0);
        rd_beats(l1, 0, 8);
        chk("t1_rdata_lo", mem_rdata[63:0], 64'h0);
        chk("t1_rdata_hi", mem_rdata[511:448], 64'h7);
        chk("t1_busy_done", mem_busy, 1'b1);
        cur_line = l1;
        @(posedge clk); #1;
        chk("t1_idle", mem_busy, 1'b0);

        // 2: write with address ack delayed 3 cycles, one beat held
        push_exp(cur_line, 1'b0, cyc + 14);
        start_req(64'h1234_5678, 1'b1, wl);
        mem_req = 1'b0;
        repeat (3) begin
            chk("t2_addr_hold", bus_req, 64'h1234_5640);
            chk("t2_addr_reqcyc", bus_reqcyc, 1'b1);
            @(posedge clk); #1;
        end
        addr_phase(64'h1234_5640, 1'b1);
        bus_reqack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                bus_reqack = 1'b0;
                @(posedge clk); #1;
                chk("t2_beat_stable", bus_req, 64'h33);
                bus_reqack = 1'b1;
            end
            chk("t2_wbeat", bus_req, 64'h11 * 64'(k));
            chk("t2_wbeat_wr", bus_req_wr, 1'b1);
            chk("t2_wbeat_reqcyc", bus_reqcyc, 1'b1);
            @(posedge clk); #1;
        end
        bus_reqack = 1'b0;
        chk("t2_done_reqcyc", bus_reqcyc, 1'b0);
        @(posedge clk); #1;

        // 3: mem_req held high; one burst, then re-accept after DONE
        push_exp(la, 1'b0, cyc + 10);
        start_req(64'h2000, 1'b0, '0);
        addr_phase(64'h2000, 1'b0);
        mem_address = 64'h3040;
        rd_beats(la, 0, 8);
        chk("t3_done_busy", mem_busy, 1'b1);
        @(posedge clk); #1;
        chk("t3_idle_busy", mem_busy, 1'b0);
        chk("t3_idle_reqcyc", bus_reqcyc, 1'b0);
        push_exp(lb, 1'b0, cyc + 10);
        @(posedge clk); #1;
        mem_req = 1'b0;
        addr_phase(64'h3040, 1'b0);
        rd_beats(lb, 0, 8);
        cur_line = lb;
        @(posedge clk); #1;

        // 4: read with 2-cycle gaps; stray respcyc during the address phase
        push_exp(lc, 1'b0, cyc + 26);
        bus_respcyc = 1'b1;
        bus_resp = 64'hBAD0_BAD0;
        start_req(64'h4000_00BF, 1'b0, '0);
        mem_req = 1'b0;
        addr_phase(64'h4000_0080, 1'b0);
        rd_beats(lc, 2, 8);
        cur_line = lc;
        @(posedge clk); #1;

        // 5: reset after beat 4 of a read
        start_req(64'h5000, 1'b0, '0);
        mem_req = 1'b0;
        addr_phase(64'h5000, 1'b0);
        rd_beats(ld, 0, 5);
        rst = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp = 64'h5555;
        @(posedge clk); #1;
        chk_reset_state();
        rst = 1'b0;
        bus_respcyc = 1'b0;
        cur_line = '0;
        @(posedge clk); #1;

        // 5b: full read after reset lands beat 0 at the bottom
        push_exp(le, 1'b0, cyc + 10);
        start_req(64'h5040, 1'b0, '0);
        mem_req = 1'b0;
        addr_phase(64'h5040, 1'b0);
        rd_beats(le, 0, 8);
        cur_line = le;
        @(posedge clk); #1;

        // 6: address never acknowledged
`ifdef MEM_TIMEOUT_EN
        push_exp(cur_line, 1'b1, cyc + 17);
        start_req(64'h6000, 1'b0, '0);
        mem_req = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("t6_tmo_busy", mem_busy, 1'b0);
        chk("t6_tmo_reqcyc", bus_reqcyc, 1'b0);
`else
        start_req(64'h6000, 1'b0, '0);
        mem_req = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("t6_wait_busy", mem_busy, 1'b1);
        chk("t6_wait_reqcyc", bus_reqcyc, 1'b1);
        chk("t6_wait_bus_req", bus_req, 64'h6000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cur_line = '0;
`endif

        // Normal read afterwards: error must be clear again
        push_exp(lf, 1'b0, cyc + 10);
        start_req(64'h7000, 1'b0, '0);
        mem_req = 1'b0;
        addr_phase(64'h7000, 1'b0);
        rd_beats(lf, 0, 8);
        cur_line = lf;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench time limit");
    end

endmodule
